bank_write_arbiter: RTL

BANK_WRITE_ARBITER -- requirements
Module: bank_write_arbiter

---
 rtl/bank_write_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/bank_write_arbiter.sv
// rtl/bank_write_arbiter.sv - three-requester round-robin write arbiter for a register bank
// Optional power-on/on-demand bank clear sweep is built only when BANK_CLEAR_EN is defined.
module bank_write_arbiter #(
    parameter int AW = 6,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           req_valid,
    input  logic [2:0][AW-1:0]   req_addr,
    input  logic [2:0][DW-1:0]   req_data,
    output logic [2:0]           req_ready,
    output logic [AW-1:0]        RegEscr,
    output logic                 EscrReg,
    output logic [DW-1:0]        datain,
    output logic                 busy,
    output logic [15:0]          conflict_cnt,
    input  logic                 clear_req
);

    logic [1:0] ptr;
    logic [1:0] gsel;
    logic       hit;
    logic [2:0] idx;
    logic       in_arb;
    logic       hs;
    logic       two_plus;

`ifdef BANK_CLEAR_EN
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_ARB   = 1'b1;

    logic [0:0]    state;
    logic [AW-1:0] clr_addr;

    // The sweep leaves CLEAR right after the top address, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    if (clr_addr == {AW{1'b1}}) begin
                        state    <= ST_ARB;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_ARB: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

    assign in_arb = (state == ST_ARB);
    assign busy   = (state == ST_CLEAR);
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign in_arb           = 1'b1;
    assign busy             = 1'b0;
`endif

    // Search order starts at ptr and wraps modulo 3.
    always_comb begin
        hit  = 1'b0;
        gsel = 2'd0;
        idx  = 3'd0;
        for (int k = 0; k < 3; k++) begin
            idx = {1'b0, ptr} + 3'(k);
            if (idx >= 3'd3) begin
                idx = idx - 3'd3;
            end
            if (!hit && req_valid[idx[1:0]]) begin
                hit  = 1'b1;
                gsel = idx[1:0];
            end
        end
    end

    assign req_ready = (hit && in_arb && rst_n) ? (3'b001 << gsel) : 3'b000;
    assign hs        = |(req_ready & req_valid);
    assign two_plus  = (req_valid[0] & req_valid[1]) |
                       (req_valid[0] & req_valid[2]) |
                       (req_valid[1] & req_valid[2]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            EscrReg      <= 1'b0;
            RegEscr      <= '0;
            datain       <= '0;
            ptr          <= 2'd0;
            conflict_cnt <= 16'd0;
        end else begin
            EscrReg <= 1'b0;
            if (hs) begin
                RegEscr <= req_addr[gsel];
                datain  <= req_data[gsel];
                EscrReg <= 1'b1;
                ptr     <= (gsel == 2'd2) ? 2'd0 : gsel + 2'd1;
            end
`ifdef BANK_CLEAR_EN
            else if (state == ST_CLEAR) begin
                RegEscr <= clr_addr;
                datain  <= '0;
                EscrReg <= 1'b1;
            end
`endif
            if (in_arb && two_plus && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

endmodule
